plot_column_sweeper: RTL and testbench
======================================

// Module: plot_column_sweeper
// PURPOSE
//   Downstream of the RPN stack machine. On plot_start, clears the 1-bpp framebuffer.
//   Then sweeps x = 0..HOR_ACTIVE_PIXELS-1, starting one stack-machine evaluation per column.
//   Each returned y is written as a lit pixel into the framebuffer write port.
//   Owns the framebuffer write side during a plot; the video scan-out reads the other side.
// PARAMETERS
//   INTEGER_PART_WIDTH     8    integer bits of the stack-machine number format
//   FRACTIONAL_PART_WIDTH  8    fractional bits (NUMBER_WIDTH = sum, in shared pkg)
//   HOR_ACTIVE_PIXELS      640  columns swept; also framebuffer row pitch
//   VER_ACTIVE_PIXELS      480  rows; y range accepted for drawing
// PORTS
//   clk         in   1                  single clock, rising edge
//   rst_n       in   1                  synchronous, active-low reset
//   plot_start  in   1                  request a full plot; sampled only in IDLE
//   plot_busy   out  1                  high from accepted plot_start until DONE
//   plot_done   out  1                  one-cycle pulse when the last column is written
//   sm_start    out  1                  one-cycle pulse to the stack machine
//   sm_x        out  INTEGER_PART_WIDTH  column index; held stable from sm_start until sm_ready
//   sm_ready    in   1                  one-cycle strobe: sm_y valid this cycle
//   sm_y        in   NUMBER_WIDTH       signed two's-complement integer row, origin at bottom
//   fb_we       out  1                  write request; held until fb_ready
//   fb_addr     out  clog2(H*V)         row*HOR_ACTIVE_PIXELS + col
//   fb_data     out  1                  1 = lit, 0 = clear
//   fb_ready    in   1                  write accepted when fb_we && fb_ready
// BEHAVIOUR
//   Reset values: all outputs 0; state IDLE; column 0. Reset mid-plot aborts at once, with no further fb writes.
//   States:
//   - IDLE: on plot_start -> CLEAR, plot_busy<=1.
//   - CLEAR: writes fb_data=0 to addr 0..H*V-1, one per accepted write; last accept -> EVAL.
//   - EVAL: sm_start=1 for one cycle, sm_x=col -> WAIT.
//   - WAIT: on sm_ready, latch sm_y -> DRAW. Before sm_ready, stay here indefinitely (no timeout).
//   - DRAW: writes lit pixel(s) for col; after last accept -> NEXT.
//   - NEXT: if col==H-1 -> DONE, else col+1 -> EVAL.
//   - DONE: plot_done=1 one cycle, plot_busy<=0 -> IDLE.
//   Row mapping: row = VER_ACTIVE_PIXELS-1-y. If y<0 or y>=VER, the pixel is clipped: no write, DRAW -> NEXT directly.
//   Write handshake: fb_we/addr/data are stable while fb_we && !fb_ready. At most one write is accepted per cycle.
//   Latency: with fb_ready=1 and sm_ready k cycles after sm_start, each in-range column costs k+4 cycles.
//   plot_start while busy is ignored. plot_start in the same cycle as DONE is ignored.
//   sm_ready outside WAIT is ignored.
//   fb_addr width = $clog2(HOR_ACTIVE_PIXELS*VER_ACTIVE_PIXELS). Address is computed without wrap.
// CONFIGURATION
//   PLOT_CONNECT_EN defined:
//   - DRAW fills rows between the previous and current column's clipped rows, inclusive, low to high.
//   - Gives a continuous curve. Column 0 (no previous) draws a single pixel.
//   - If both ends are off-screen on the same side, nothing is drawn. A clipped end is clamped to 0 or VER-1.
//   - The previous y register is updated every column, including clipped ones.
//   PLOT_CONNECT_EN undefined: exactly one pixel per in-range column.
// STRUCTURE
//   Shared package plot_pkg:
//   - NUMBER_WIDTH, the number_t typedef, and the sweeper state enum.
//   - fb_addr_w(H,V) constant function.
//   Sub-module fb_row_mapper (combinational): y -> {in_range, clamped row}. Shared with scan-out overlay.
// TESTING (H=8, V=8 unless stated)
//   Clear: plot_start -> 64 writes data=0 to addr 0..63 in order, then sm_start with sm_x=0.
//   Identity: model sm_y=x after 3 cycles -> writes addr (7-x)*8+x for x=0..7; plot_done once; busy falls.
//   Clip: sm_y=-1 at x=2 and sm_y=8 at x=5 -> no lit write for cols 2 and 5; other cols written.
//   Backpressure: fb_ready toggling 1/0 -> fb_we/addr/data hold steady while stalled; no write lost or duplicated.
//   Connect (PLOT_CONNECT_EN): y=1 then y=5 -> col1 writes rows 2..6 (addr 17,25,33,41,49); col0 writes a single pixel.
//   Abort: rst_n=0 during WAIT at x=4 -> next cycle all outputs 0; a later plot_start restarts from CLEAR.

Source files
------------

// File: rtl/plot_pkg.sv
// Shared number format, sweeper state encoding and framebuffer address sizing
// for the plot column sweeper and the scan-out overlay.
package plot_pkg;

    localparam int PLOT_INT_BITS  = 8;
    localparam int PLOT_FRAC_BITS = 8;
    localparam int NUMBER_WIDTH   = PLOT_INT_BITS + PLOT_FRAC_BITS;

    typedef logic signed [NUMBER_WIDTH-1:0] number_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_EVAL,
        ST_WAIT,
        ST_DRAW,
        ST_NEXT,
        ST_DONE
    } sweep_state_t;

    function automatic int fb_addr_w(input int h, input int v);
        return (h * v > 1) ? $clog2(h * v) : 1;
    endfunction

endpackage

// File: rtl/fb_row_mapper.sv
// Maps a signed y (origin at the bottom) to a framebuffer row (origin at the top).
// Off-screen values report in_range=0 and clamp to the nearest edge row.
module fb_row_mapper #(
    parameter int Y_WIDTH           = plot_pkg::NUMBER_WIDTH,
    parameter int VER_ACTIVE_PIXELS = 480,
    parameter int ROW_W             = (VER_ACTIVE_PIXELS > 1) ? $clog2(VER_ACTIVE_PIXELS) : 1
) (
    input  logic [Y_WIDTH-1:0] y,
    output logic               in_range,
    output logic [ROW_W-1:0]   row
);

    logic signed [31:0] y_int;

    always_comb begin
        y_int    = 32'($signed(y));
        in_range = 1'b0;
        row      = '0;
        if (y_int < 0) begin
            row = ROW_W'(VER_ACTIVE_PIXELS - 1);
        end else if (y_int >= VER_ACTIVE_PIXELS) begin
            row = '0;
        end else begin
            in_range = 1'b1;
            row      = ROW_W'(VER_ACTIVE_PIXELS - 1 - y_int);
        end
    end

endmodule

// File: rtl/plot_column_sweeper.sv
// Clears the 1-bpp framebuffer, then evaluates one stack-machine result per column and plots it.
// Define PLOT_CONNECT_EN to join each column to the previous one with a vertical run of pixels.
module plot_column_sweeper
    import plot_pkg::*;
#(
    parameter int INTEGER_PART_WIDTH    = PLOT_INT_BITS,
    parameter int FRACTIONAL_PART_WIDTH = PLOT_FRAC_BITS,
    parameter int HOR_ACTIVE_PIXELS     = 640,
    parameter int VER_ACTIVE_PIXELS     = 480
) (
    input  logic                                                 clk,
    input  logic                                                 rst_n,
    input  logic                                                 plot_start,
    output logic                                                 plot_busy,
    output logic                                                 plot_done,
    output logic                                                 sm_start,
    output logic [INTEGER_PART_WIDTH-1:0]                        sm_x,
    input  logic                                                 sm_ready,
    input  logic [INTEGER_PART_WIDTH+FRACTIONAL_PART_WIDTH-1:0]  sm_y,
    output logic                                                 fb_we,
    output logic [fb_addr_w(HOR_ACTIVE_PIXELS, VER_ACTIVE_PIXELS)-1:0] fb_addr,
    output logic                                                 fb_data,
    input  logic                                                 fb_ready
);

    localparam int NW     = INTEGER_PART_WIDTH + FRACTIONAL_PART_WIDTH;
    localparam int ADDR_W = fb_addr_w(HOR_ACTIVE_PIXELS, VER_ACTIVE_PIXELS);
    localparam int COL_W  = (HOR_ACTIVE_PIXELS > 1) ? $clog2(HOR_ACTIVE_PIXELS) : 1;
    localparam int ROW_W  = (VER_ACTIVE_PIXELS > 1) ? $clog2(VER_ACTIVE_PIXELS) : 1;
    localparam int CELLS  = HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS;

    sweep_state_t      state, next_state;
    logic [COL_W-1:0]  col;
    logic [ADDR_W-1:0] clear_addr;
    logic [NW-1:0]     y_reg;
    logic [ROW_W-1:0]  draw_row, draw_end;
    logic              draw_armed;

    logic              cur_in;
    logic [ROW_W-1:0]  cur_row;
    logic              span_valid;
    logic [ROW_W-1:0]  span_lo, span_hi;

    fb_row_mapper #(
        .Y_WIDTH          (NW),
        .VER_ACTIVE_PIXELS(VER_ACTIVE_PIXELS),
        .ROW_W            (ROW_W)
    ) u_cur_map (
        .y       (y_reg),
        .in_range(cur_in),
        .row     (cur_row)
    );

`ifdef PLOT_CONNECT_EN
    logic [NW-1:0]    prev_y;
    logic             prev_in;
    logic [ROW_W-1:0] prev_row;

    fb_row_mapper #(
        .Y_WIDTH          (NW),
        .VER_ACTIVE_PIXELS(VER_ACTIVE_PIXELS),
        .ROW_W            (ROW_W)
    ) u_prev_map (
        .y       (prev_y),
        .in_range(prev_in),
        .row     (prev_row)
    );

    // Both ends off-screen on the same side (equal sign bits) leaves nothing to draw.
    always_comb begin
        span_valid = cur_in;
        span_lo    = cur_row;
        span_hi    = cur_row;
        if (col != '0) begin
            span_valid = cur_in || prev_in || (y_reg[NW-1] != prev_y[NW-1]);
            span_lo    = (cur_row < prev_row) ? cur_row : prev_row;
            span_hi    = (cur_row < prev_row) ? prev_row : cur_row;
        end
    end
`else
    always_comb begin
        span_valid = cur_in;
        span_lo    = cur_row;
        span_hi    = cur_row;
    end
`endif

    assign plot_busy = (state != ST_IDLE);
    assign sm_x      = INTEGER_PART_WIDTH'(col);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    // DRAW spends its first cycle latching the row span, then issues one write per row.
    always_comb begin
        next_state = state;
        sm_start   = 1'b0;
        plot_done  = 1'b0;
        fb_we      = 1'b0;
        fb_addr    = '0;
        fb_data    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (plot_start) next_state = ST_CLEAR;
            end
            ST_CLEAR: begin
                fb_we   = 1'b1;
                fb_addr = clear_addr;
                if (fb_ready && clear_addr == ADDR_W'(CELLS - 1)) next_state = ST_EVAL;
            end
            ST_EVAL: begin
                sm_start   = 1'b1;
                next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (sm_ready) next_state = ST_DRAW;
            end
            ST_DRAW: begin
                if (!draw_armed) begin
                    if (!span_valid) next_state = ST_NEXT;
                end else begin
                    fb_we   = 1'b1;
                    fb_data = 1'b1;
                    fb_addr = ADDR_W'(int'(draw_row) * HOR_ACTIVE_PIXELS + int'(col));
                    if (fb_ready && draw_row == draw_end) next_state = ST_NEXT;
                end
            end
            ST_NEXT: begin
                next_state = (col == COL_W'(HOR_ACTIVE_PIXELS - 1)) ? ST_DONE : ST_EVAL;
            end
            ST_DONE: begin
                plot_done  = 1'b1;
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col        <= '0;
            clear_addr <= '0;
            y_reg      <= '0;
            draw_row   <= '0;
            draw_end   <= '0;
            draw_armed <= 1'b0;
`ifdef PLOT_CONNECT_EN
            prev_y     <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    col        <= '0;
                    clear_addr <= '0;
                    draw_armed <= 1'b0;
                end
                ST_CLEAR: begin
                    if (fb_ready) clear_addr <= clear_addr + 1'b1;
                end
                ST_WAIT: begin
                    if (sm_ready) y_reg <= sm_y;
                end
                ST_DRAW: begin
                    if (!draw_armed) begin
                        if (span_valid) begin
                            draw_armed <= 1'b1;
                            draw_row   <= span_lo;
                            draw_end   <= span_hi;
                        end
                    end else if (fb_ready) begin
                        if (draw_row == draw_end) draw_armed <= 1'b0;
                        else                      draw_row   <= draw_row + 1'b1;
                    end
                end
                ST_NEXT: begin
                    col <= col + 1'b1;
`ifdef PLOT_CONNECT_EN
                    prev_y <= y_reg;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_plot_column_sweeper.sv
// Self-checking bench for plot_column_sweeper on an 8x8 framebuffer with a
// behavioural stack-machine responder and a write-list reference model.
module tb_plot_column_sweeper;
    import plot_pkg::*;

    localparam int H  = 8;
    localparam int V  = 8;
    localparam int IW = 8;
    localparam int FW = 8;
    localparam int NW = IW + FW;
    localparam int AW = 6;
`ifdef PLOT_CONNECT_EN
    localparam bit CONNECT = 1'b1;
`else
    localparam bit CONNECT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          plot_start;
    logic          plot_busy;
    logic          plot_done;
    logic          sm_start;
    logic [IW-1:0] sm_x;
    logic          sm_ready;
    logic [NW-1:0] sm_y;
    logic          fb_we;
    logic [AW-1:0] fb_addr;
    logic          fb_data;
    logic          fb_ready;

    plot_column_sweeper #(
        .INTEGER_PART_WIDTH   (IW),
        .FRACTIONAL_PART_WIDTH(FW),
        .HOR_ACTIVE_PIXELS    (H),
        .VER_ACTIVE_PIXELS    (V)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .plot_start(plot_start),
        .plot_busy (plot_busy),
        .plot_done (plot_done),
        .sm_start  (sm_start),
        .sm_x      (sm_x),
        .sm_ready  (sm_ready),
        .sm_y      (sm_y),
        .fb_we     (fb_we),
        .fb_addr   (fb_addr),
        .fb_data   (fb_data),
        .fb_ready  (fb_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int                   lat;
        int                   rmode;
        logic [H-1:0][NW-1:0] yv;
        int                   exp_lits;
        int                   chk_gap;
    } vec_t;

    vec_t vecs[3];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int cfg_lat  = 1;
    int ready_mode = 0;
    int cfg_y[H];
    int spur_cnt = 0;

    int wr_addr[$];
    int wr_data[$];
    int wr_cyc[$];
    int start_cyc[$];
    int start_x[$];
    int exp_q[$];
    int stall_err = 0;
    int done_cnt  = 0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
    endtask

    function automatic int row_of(input int y);
        if (y < 0)  return V - 1;
        if (y >= V) return 0;
        return V - 1 - y;
    endfunction

    function automatic int side_of(input int y);
        if (y < 0)  return -1;
        if (y >= V) return 1;
        return 0;
    endfunction

    // Expected lit-pixel addresses in write order for one full plot.
    function automatic void build_model(input logic [H-1:0][NW-1:0] yv);
        int y;
`ifdef PLOT_CONNECT_EN
        int yp, lo, hi;
`endif
        exp_q.delete();
        for (int x = 0; x < H; x++) begin
            y = int'($signed(yv[x]));
`ifdef PLOT_CONNECT_EN
            if (x == 0) begin
                if (side_of(y) == 0) exp_q.push_back(row_of(y) * H + x);
            end else begin
                yp = int'($signed(yv[x-1]));
                if (!(side_of(y) != 0 && side_of(y) == side_of(yp))) begin
                    lo = (row_of(y) < row_of(yp)) ? row_of(y) : row_of(yp);
                    hi = (row_of(y) < row_of(yp)) ? row_of(yp) : row_of(y);
                    for (int r = lo; r <= hi; r++) exp_q.push_back(r * H + x);
                end
            end
`else
            if (side_of(y) == 0) exp_q.push_back(row_of(y) * H + x);
`endif
        end
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        fb_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       fb_ready = 1'b1;
                1:       fb_ready = ~fb_ready;
                default: fb_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Stack-machine stand-in: answers cfg_y[x] cfg_lat cycles after sm_start.
    initial begin
        int xi;
        int spur_done;
        spur_done = 0;
        sm_ready  = 1'b0;
        sm_y      = '0;
        forever begin
            @(negedge clk);
            if (sm_start) begin
                xi = int'(sm_x);
                if (xi >= H) xi = 0;
                repeat (cfg_lat) @(posedge clk);
                #1;
                sm_ready = 1'b1;
                sm_y     = NW'(cfg_y[xi]);
                @(posedge clk);
                #1 sm_ready = 1'b0;
            end else if (spur_cnt != spur_done) begin
                spur_done++;
                @(posedge clk);
                #1;
                sm_ready = 1'b1;
                sm_y     = NW'(3);
                @(posedge clk);
                #1 sm_ready = 1'b0;
            end
        end
    end

    // Monitor: logs accepted writes and column starts, flags unstable stalled outputs.
    initial begin
        bit stall_prev;
        int stall_addr, stall_data;
        bit waiting;
        int wait_x;
        stall_prev = 1'b0;
        stall_addr = 0;
        stall_data = 0;
        waiting    = 1'b0;
        wait_x     = 0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                waiting    = 1'b0;
                stall_prev = 1'b0;
            end else begin
                if (stall_prev && (!fb_we || int'(fb_addr) != stall_addr || int'(fb_data) != stall_data))
                    stall_err++;
                stall_prev = fb_we && !fb_ready;
                stall_addr = int'(fb_addr);
                stall_data = int'(fb_data);
                if (fb_we && fb_ready) begin
                    wr_addr.push_back(int'(fb_addr));
                    wr_data.push_back(int'(fb_data));
                    wr_cyc.push_back(cyc);
                end
                if (sm_start) begin
                    start_cyc.push_back(cyc);
                    start_x.push_back(int'(sm_x));
                    waiting = 1'b1;
                    wait_x  = int'(sm_x);
                end else if (waiting) begin
                    if (int'(sm_x) != wait_x) stall_err++;
                    if (sm_ready) waiting = 1'b0;
                end
                if (plot_done) done_cnt++;
            end
        end
    end

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},     int'(plot_busy), 0);
        check({tag, "_done"},     int'(plot_done), 0);
        check({tag, "_sm_start"}, int'(sm_start),  0);
        check({tag, "_sm_x"},     int'(sm_x),      0);
        check({tag, "_fb_we"},    int'(fb_we),     0);
        check({tag, "_fb_addr"},  int'(fb_addr),   0);
        check({tag, "_fb_data"},  int'(fb_data),   0);
    endtask

    task automatic run_plot(input int lat, input int rmode, input logic [H-1:0][NW-1:0] yv,
                            input int exp_lits, input int chk_gap);
        int wb, sb, db, eb, got, errs, nlit, ok;
        cfg_lat    = lat;
        ready_mode = rmode;
        for (int x = 0; x < H; x++) cfg_y[x] = int'($signed(yv[x]));
        build_model(yv);
        @(posedge clk);
        #1;
        wb = wr_addr.size();
        sb = start_cyc.size();
        db = done_cnt;
        eb = stall_err;
        plot_start = 1'b1;
        @(posedge clk);
        #1 plot_start = 1'b0;
        repeat (4) @(posedge clk);
        spur_cnt++;
        repeat (20) @(posedge clk);
        #1 plot_start = 1'b1;
        @(posedge clk);
        #1 plot_start = 1'b0;
        got = 0;
        for (int i = 0; i < 8000 && got == 0; i++) begin
            @(negedge clk);
            if (plot_done) got = 1;
        end
        check("done_seen", got, 1);
        if (got == 1) begin
            plot_start = 1'b1;
            @(posedge clk);
            #1 plot_start = 1'b0;
        end
        repeat (3) @(negedge clk);
        check("busy_low_after_done", int'(plot_busy), 0);
        check("done_pulse_count", done_cnt - db, 1);
        check("stall_hold", stall_err - eb, 0);

        errs = 0;
        if (wr_addr.size() - wb < H * V) errs = H * V;
        else for (int i = 0; i < H * V; i++)
            if (wr_addr[wb+i] != i || wr_data[wb+i] != 0) errs++;
        check("clear_seq", errs, 0);

        ok = 0;
        if (errs == 0 && start_cyc.size() > sb) ok = int'(wr_cyc[wb+H*V-1] < start_cyc[sb]);
        check("clear_before_eval", ok, 1);

        nlit = wr_addr.size() - wb - H * V;
        if (nlit < 0) nlit = 0;
        check("lit_count", nlit, exp_q.size());
        if (exp_lits >= 0) check("lit_count_table", nlit, exp_lits);
        errs = 0;
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= nlit) errs++;
            else if (wr_addr[wb+H*V+i] != exp_q[i] || wr_data[wb+H*V+i] != 1) errs++;
        check("lit_addrs", errs, 0);

        errs = 0;
        if (start_x.size() - sb != H) errs = 99;
        else for (int i = 0; i < H; i++) if (start_x[sb+i] != i) errs++;
        check("sm_x_order", errs, 0);

        if (chk_gap != 0) begin
            errs = 0;
            if (start_cyc.size() - sb != H) errs = 99;
            else for (int i = 1; i < H; i++)
                if (start_cyc[sb+i] - start_cyc[sb+i-1] != lat + 4) errs++;
            check("col_latency", errs, 0);
        end
    endtask

    initial begin
        int clip_y[H];
        int got, wrs;
        logic [H-1:0][NW-1:0] ry;
        logic [H-1:0][NW-1:0] ident;
        clip_y = '{0, 1, -1, 3, 4, 8, 6, 7};
        for (int x = 0; x < H; x++) ident[x] = NW'(x);

        vecs[0].lat = 3; vecs[0].rmode = 0; vecs[0].yv = ident;
        vecs[0].exp_lits = CONNECT ? 15 : 8; vecs[0].chk_gap = CONNECT ? 0 : 1;
        vecs[1].lat = 2; vecs[1].rmode = 1;
        for (int x = 0; x < H; x++) vecs[1].yv[x] = NW'(clip_y[x]);
        vecs[1].exp_lits = CONNECT ? 19 : 6; vecs[1].chk_gap = 0;
        vecs[2].lat = 1; vecs[2].rmode = 0;
        for (int x = 0; x < H; x++) vecs[2].yv[x] = NW'((x == 0) ? 1 : 5);
        vecs[2].exp_lits = CONNECT ? 12 : 8; vecs[2].chk_gap = CONNECT ? 0 : 1;

        rst_n      = 1'b0;
        plot_start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 3; i++)
            run_plot(vecs[i].lat, vecs[i].rmode, vecs[i].yv, vecs[i].exp_lits, vecs[i].chk_gap);

        for (int r = 0; r < 4; r++) begin
            for (int x = 0; x < H; x++) ry[x] = NW'(int'($urandom_range(0, 13)) - 3);
            run_plot(int'($urandom_range(1, 4)), 2, ry, -1, 0);
        end

        // Abort while the stack machine is evaluating column 4.
        cfg_lat    = 3;
        ready_mode = 0;
        for (int x = 0; x < H; x++) cfg_y[x] = x;
        @(posedge clk);
        #1 plot_start = 1'b1;
        @(posedge clk);
        #1 plot_start = 1'b0;
        got = 0;
        for (int i = 0; i < 4000 && got == 0; i++) begin
            @(negedge clk);
            if (sm_start && sm_x == IW'(4)) got = 1;
        end
        check("abort_reach_x4", got, 1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_idle_outputs("abort");
        wrs = 0;
        repeat (4) begin
            @(negedge clk);
            if (fb_we) wrs++;
        end
        check("abort_no_writes", wrs, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        run_plot(2, 1, ident, CONNECT ? 15 : 8, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
